// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: IM geometry and the
// loader FSM state encoding.
package im_loader_pkg;

  // Default IM word-address width and the matching IM depth in words.
  localparam int ADDR_W   = 10;
  localparam int IM_DEPTH = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_VWAIT  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/im_loader.sv
// Instruction-memory loader: streams word_len source words into IM starting at
// address 0, optionally reads them back to confirm the checksum, and holds the
// CPU in reset until the image is known good.
module im_loader #(
  parameter int ADDR_W = im_loader_pkg::ADDR_W,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              IM_enable_mem,
  output logic              IM_enable_write,
  output logic              IM_enable_fetch,
  output logic [ADDR_W-1:0] IM_address,
  output logic [31:0]       IMin,
  input  logic [31:0]       IMout,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  import im_loader_pkg::*;

  // Largest legal load is the full address space; a count of one marks the
  // final word of a pass.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     len_q;
  logic [31:0]         sum;
  logic [31:0]         rsum;
  logic [31:0]         rsum_nxt;
  logic                len_ok;
  logic                accept;
  logic                last;

  assign len_ok   = (word_len != '0) && (word_len <= MAX_LEN);
  assign accept   = (state == S_WRITE) && s_valid;
  assign last     = (cnt == ONE);
  assign rsum_nxt = rsum + IMout;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start outside the busy states always restarts a load.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = len_ok ? S_WRITE : S_ERROR;
      end
      S_WRITE: begin
        if (accept && last) state_nxt = (VERIFY != 0) ? S_VERIFY : S_DONE;
      end
      S_VERIFY: state_nxt = S_VWAIT;
      S_VWAIT: begin
        if (last) state_nxt = (rsum_nxt == sum) ? S_DONE : S_ERROR;
        else      state_nxt = S_VERIFY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, word counter and the write/read-back running sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
      sum   <= '0;
      rsum  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start && len_ok) begin
            addr  <= '0;
            cnt   <= word_len;
            len_q <= word_len;
            sum   <= '0;
            rsum  <= '0;
          end
        end
        S_WRITE: begin
          if (accept) begin
            sum <= sum + s_data;
            if (last) begin
              // Rewind for the read-back pass; a full-depth load never wraps.
              addr <= '0;
              cnt  <= len_q;
              rsum <= '0;
            end else begin
              addr <= addr + 1'b1;
              cnt  <= cnt - 1'b1;
            end
          end
        end
        S_VWAIT: begin
          rsum <= rsum_nxt;
          cnt  <= cnt - 1'b1;
          addr <= last ? '0 : addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: IM strobes and write data pass straight through from the source.
  always_comb begin
    s_ready         = 1'b0;
    IM_enable_write = 1'b0;
    IM_enable_fetch = 1'b0;
    IMin            = '0;
    case (state)
      S_WRITE: begin
        s_ready         = 1'b1;
        IM_enable_write = s_valid;
        IMin            = s_valid ? s_data : '0;
      end
      S_VERIFY: IM_enable_fetch = 1'b1;
      default: ;
    endcase
    IM_enable_mem = IM_enable_write | IM_enable_fetch;
    IM_address    = addr;
    busy          = (state == S_WRITE) || (state == S_VERIFY) || (state == S_VWAIT);
    done          = (state == S_DONE);
    error         = (state == S_ERROR);
    cpu_rst       = (state != S_DONE);
    checksum      = sum;
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a verifying instance and a non-verifying instance, each
// beside its own IM model. A scoreboard of expected IM writes/fetches and a
// running checksum is checked every cycle; directed loads pin the results.
module tb_im_loader;

  import im_loader_pkg::*;

  localparam int AW = ADDR_W;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_nv;
  logic [AW:0]   word_len;
  logic          s_valid;
  logic [31:0]   s_data;

  logic          s_ready, mem, wr, fe, cpu_rst, busy, done, error;
  logic [AW-1:0] addr;
  logic [31:0]   imin, imout, checksum;

  logic          s_ready_nv, mem_nv, wr_nv, fe_nv, cpu_rst_nv, busy_nv, done_nv, error_nv;
  logic [AW-1:0] addr_nv;
  logic [31:0]   imin_nv, imout_nv, checksum_nv;

  logic [31:0]   im    [IM_DEPTH];
  logic [31:0]   im_nv [IM_DEPTH];
  logic [31:0]   words [IM_DEPTH];
  logic          fill_req = 1'b0;
  logic          corrupt  = 1'b0;

  wr_t           exp_wr[$];
  wr_t           exp_wr_nv[$];
  logic [AW-1:0] exp_rd[$];
  logic [31:0]   model_sum = '0;
  logic [31:0]   model_sum_nv = '0;
  int            max_addr_nv = 0;
  int            fetch_cnt_nv = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  im_loader #(.ADDR_W(AW), .VERIFY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .word_len(word_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .IM_enable_mem(mem), .IM_enable_write(wr), .IM_enable_fetch(fe),
    .IM_address(addr), .IMin(imin), .IMout(imout),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  im_loader #(.ADDR_W(AW), .VERIFY(0)) dut_nv (
    .clk(clk), .rst(rst), .start(start_nv), .word_len(word_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_nv),
    .IM_enable_mem(mem_nv), .IM_enable_write(wr_nv), .IM_enable_fetch(fe_nv),
    .IM_address(addr_nv), .IMin(imin_nv), .IMout(imout_nv),
    .cpu_rst(cpu_rst_nv), .busy(busy_nv), .done(done_nv), .error(error_nv),
    .checksum(checksum_nv)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // IM models: synchronous write, one-cycle read latency, optional corruption
  // of the word returned for address 2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int i = 0; i < IM_DEPTH; i++) begin
        im[i]    <= pat(i);
        im_nv[i] <= pat(i);
      end
    end
    if (mem && wr) im[addr] <= imin;
    if (mem && fe) imout <= (corrupt && addr == 2) ? (im[addr] ^ 32'h0000_0100) : im[addr];
    if (mem_nv && wr_nv) im_nv[addr_nv] <= imin_nv;
    if (mem_nv && fe_nv) imout_nv <= im_nv[addr_nv];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t           e;
    logic [AW-1:0] ra;
    if (!rst) begin
      check("wr_fetch_exclusive", {31'b0, wr && fe}, 32'd0);
      check("wr_strobe_rule", {31'b0, wr}, {31'b0, s_ready && s_valid});
      check("mem_strobe_rule", {31'b0, mem}, {31'b0, wr || fe});
      if (s_ready) check("ready_implies_busy", {31'b0, busy}, 32'd1);
      if (busy) check("checksum_running", checksum, model_sum);
      if (wr) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(addr), 32'(e.a));
          check("wr_data", imin, e.d);
          model_sum += e.d;
        end
      end
      if (fe) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_fetch", 32'd1, 32'd0);
        end else begin
          ra = exp_rd.pop_front();
          check("fetch_addr", 32'(addr), 32'(ra));
        end
      end

      check("nv_wr_fetch_exclusive", {31'b0, wr_nv && fe_nv}, 32'd0);
      check("nv_wr_strobe_rule", {31'b0, wr_nv}, {31'b0, s_ready_nv && s_valid});
      check("nv_no_fetch", {31'b0, fe_nv}, 32'd0);
      if (busy_nv) check("nv_checksum_running", checksum_nv, model_sum_nv);
      if (fe_nv) fetch_cnt_nv++;
      if (wr_nv) begin
        if (int'(addr_nv) > max_addr_nv) max_addr_nv = int'(addr_nv);
        if (exp_wr_nv.size() == 0) begin
          check("nv_unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_wr_nv.pop_front();
          check("nv_wr_addr", 32'(addr_nv), 32'(e.a));
          check("nv_wr_data", imin_nv, e.d);
          model_sum_nv += e.d;
        end
      end
    end
  end

  task automatic fill_im();
    fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Starts a load of words[0..n-1] and feeds source words until stop_after
  // have been accepted; stall drops s_valid on even cycles, poke pulses start
  // mid-load. Reports the cycle of the first accept and WRITE-phase length.
  task automatic run_load(input bit nv, input int n, input bit stall, input bit poke,
                          input int stop_after, output int t_first, output int wr_cycles);
    int   idx;
    int   phase;
    logic rdy;
    logic acc;
    for (int i = 0; i < stop_after; i++) begin
      if (nv) exp_wr_nv.push_back('{a: AW'(i), d: words[i]});
      else    exp_wr.push_back('{a: AW'(i), d: words[i]});
    end
    if (!nv && stop_after >= n)
      for (int i = 0; i < n; i++) exp_rd.push_back(AW'(i));
    if (nv) model_sum_nv = '0;
    else    model_sum = '0;

    word_len = (AW+1)'(n);
    if (nv) start_nv = 1'b1;
    else    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_nv = 1'b0;
    check("start_enters_busy", {31'b0, nv ? busy_nv : busy}, 32'd1);
    check("start_raises_cpu_rst", {31'b0, nv ? cpu_rst_nv : cpu_rst}, 32'd1);

    idx = 0;
    phase = 0;
    t_first = -1;
    wr_cycles = 0;
    while (idx < stop_after && phase < 4 * n + 16) begin
      rdy = nv ? s_ready_nv : s_ready;
      s_valid = stall ? (phase % 2 == 1) : 1'b1;
      s_data = s_valid ? words[idx] : (32'hBAD0_0000 | 32'(phase));
      if (poke && phase == 1) begin
        start = 1'b1;
        word_len = (AW+1)'(7);
      end else begin
        start = 1'b0;
      end
      if (rdy) wr_cycles++;
      acc = s_valid && rdy;
      if (acc && t_first < 0) t_first = cyc;
      @(posedge clk); #1;
      if (acc) idx++;
      phase++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    check("load_accepted_all", 32'(idx), 32'(stop_after));
  endtask

  // Waits (bounded) for done or error; returns the cycle done was first seen.
  task automatic wait_finish(input bit nv, input int budget, output int t_end);
    int k;
    k = 0;
    t_end = -1;
    while (!(nv ? (done_nv || error_nv) : (done || error)) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (nv ? (done_nv || error_nv) : (done || error)) t_end = cyc;
    else check("finish_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int tf, te, wc, bad;
    logic [31:0] exp_sum;

    rst = 1'b1;
    start = 1'b0;
    start_nv = 1'b0;
    word_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    fill_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fill_req = 1'b0;

    // Reset state.
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("rst_strobes", {29'b0, mem, wr, fe}, 32'd0);
    check("rst_address", 32'(addr), 32'd0);
    check("rst_imin", imin, 32'd0);
    check("rst_flags", {28'b0, s_ready, busy, done, error}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_nv_flags", {27'b0, cpu_rst_nv, s_ready_nv, busy_nv, done_nv, error_nv}, 32'h10);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four words, continuous source.
    words[0] = 32'h0000_0001;
    words[1] = 32'h0000_0002;
    words[2] = 32'h0000_0003;
    words[3] = 32'hFFFF_FFFF;
    run_load(1'b0, 4, 1'b0, 1'b0, 4, tf, wc);
    wait_finish(1'b0, 40, te);
    check("t1_done", {30'b0, done, error}, 32'h2);
    check("t1_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("t1_checksum", checksum, 32'h0000_0005);
    check("t1_cpu_rst_fall_cycles", 32'(te - tf), 32'd12);
    check("t1_write_cycles", 32'(wc), 32'd4);
    check("t1_im0", im[0], 32'h0000_0001);
    check("t1_im1", im[1], 32'h0000_0002);
    check("t1_im2", im[2], 32'h0000_0003);
    check("t1_im3", im[3], 32'hFFFF_FFFF);
    check("t1_queues_drained", 32'(exp_wr.size() + exp_rd.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_held", {31'b0, done}, 32'd1);
    check("t1_checksum_held", checksum, 32'h0000_0005);

    // Same load from DONE, source stalls every other cycle, stray start mid-load.
    fill_im();
    run_load(1'b0, 4, 1'b1, 1'b1, 4, tf, wc);
    wait_finish(1'b0, 40, te);
    check("t2_write_cycles", 32'(wc), 32'd8);
    check("t2_done", {30'b0, done, error}, 32'h2);
    check("t2_checksum", checksum, 32'h0000_0005);
    for (int i = 0; i < 4; i++) check("t2_im", im[i], words[i]);
    check("t2_im4_untouched", im[4], pat(4));
    check("t2_queues_drained", 32'(exp_wr.size() + exp_rd.size()), 32'd0);

    // Read-back of address 2 corrupted.
    corrupt = 1'b1;
    fill_im();
    run_load(1'b0, 4, 1'b0, 1'b0, 4, tf, wc);
    wait_finish(1'b0, 40, te);
    check("t3_error", {30'b0, done, error}, 32'h1);
    check("t3_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("t3_all_fetched", 32'(exp_rd.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_error_held", {29'b0, cpu_rst, done, error}, 32'h5);
    corrupt = 1'b0;

    // Illegal lengths.
    pulse_rst();
    check("t4_rst_clears_error", {31'b0, error}, 32'd0);
    word_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_len0_error", {29'b0, error, busy, done}, 32'h4);
    check("t4_len0_no_strobe", {31'b0, mem}, 32'd0);
    pulse_rst();
    word_len = (AW+1)'(1025);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_len1025_error", {29'b0, error, busy, done}, 32'h4);
    check("t4_len1025_cpu_rst", {31'b0, cpu_rst}, 32'd1);

    // Reset after two of four words, then a clean reload.
    pulse_rst();
    fill_im();
    words[0] = 32'h0000_0011;
    words[1] = 32'h0000_0022;
    words[2] = 32'h0000_0033;
    words[3] = 32'h0000_0044;
    run_load(1'b0, 4, 1'b0, 1'b0, 2, tf, wc);
    pulse_rst();
    check("t5_abort_idle", {29'b0, busy, s_ready, cpu_rst}, 32'h1);
    check("t5_abort_checksum", checksum, 32'd0);
    check("t5_im0", im[0], 32'h0000_0011);
    check("t5_im1", im[1], 32'h0000_0022);
    check("t5_im2_untouched", im[2], pat(2));
    check("t5_im3_untouched", im[3], pat(3));
    check("t5_unwritten_left", 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
    run_load(1'b0, 4, 1'b0, 1'b0, 4, tf, wc);
    wait_finish(1'b0, 40, te);
    check("t5_reload_done", {29'b0, cpu_rst, done, error}, 32'h2);
    check("t5_reload_checksum", checksum, 32'h0000_00AA);
    for (int i = 0; i < 4; i++) check("t5_reload_im", im[i], words[i]);

    // Full-depth load without read-back.
    exp_sum = '0;
    for (int i = 0; i < IM_DEPTH; i++) begin
      words[i] = 32'hC000_0000 + 32'(i);
      exp_sum += words[i];
    end
    max_addr_nv = 0;
    fetch_cnt_nv = 0;
    run_load(1'b1, IM_DEPTH, 1'b0, 1'b0, IM_DEPTH, tf, wc);
    wait_finish(1'b1, 40, te);
    check("t6_done", {29'b0, cpu_rst_nv, done_nv, error_nv}, 32'h2);
    check("t6_checksum", checksum_nv, 32'h0007_FE00);
    check("t6_checksum_model", checksum_nv, exp_sum);
    check("t6_max_address", 32'(max_addr_nv), 32'd1023);
    check("t6_fetch_count", 32'(fetch_cnt_nv), 32'd0);
    check("t6_done_latency", 32'(te - tf), 32'd1024);
    bad = 0;
    for (int i = 0; i < IM_DEPTH; i++) if (im_nv[i] !== words[i]) bad++;
    check("t6_im_contents_bad", 32'(bad), 32'd0);
    check("t6_queue_drained", 32'(exp_wr_nv.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
